// File: rtl/cpu_pkg.sv
// Shared CPU field widths and dispatch entry layout, reused by the
// decode/dispatch/issue blocks.
package cpu_pkg;

  localparam int unsigned INST_W     = 83;
  localparam int unsigned REG_ADDR_W = 5;

  typedef struct packed {
    logic [INST_W-1:0]     inst;
    logic [REG_ADDR_W-1:0] rd;
    logic                  map_en;
  } dispatch_entry_t;

  // Encoding equals {push, pop} so the control can cast it directly.
  typedef enum logic [1:0] {
    Q_IDLE = 2'b00,
    Q_POP  = 2'b01,
    Q_PUSH = 2'b10,
    Q_BOTH = 2'b11
  } queue_op_e;

endpackage

// File: rtl/dispatch_queue_ctrl.sv
// Pointer/count bookkeeping for dispatch_queue: full/empty, handshake
// qualification and single-cycle flush.
module dispatch_queue_ctrl
  import cpu_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             out_ready,
  input  logic             bypass,
  output logic             in_ready,
  output logic             empty,
  output logic             push,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [PTR_W:0]   count
);

  localparam int unsigned   CNT_W      = PTR_W + 1;
  localparam logic [PTR_W:0] FULL_COUNT = CNT_W'(DEPTH);

  logic      pop;
  queue_op_e op;

  // in_ready depends on registered count only, so a full queue refuses
  // a push even while it pops.
  assign in_ready = (count != FULL_COUNT);
  assign empty    = (count == '0);
  assign push     = in_valid && in_ready && !bypass;
  assign pop      = !empty && out_ready;
  assign op       = queue_op_e'({push, pop});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      case (op)
        Q_PUSH: begin
          wr_ptr <= wr_ptr + 1'b1;
          count  <= count + 1'b1;
        end
        Q_POP: begin
          rd_ptr <= rd_ptr + 1'b1;
          count  <= count - 1'b1;
        end
        Q_BOTH: begin
          wr_ptr <= wr_ptr + 1'b1;
          rd_ptr <= rd_ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dispatch_queue.sv
// In-order elastic queue between decode and issue with one-cycle flush.
// Optional DISPATCH_BYPASS_EN: empty-queue 0-cycle pass-through to out_*.
module dispatch_queue #(
  parameter  int unsigned DEPTH  = 4,
  parameter  int unsigned INST_W = cpu_pkg::INST_W,
  localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [INST_W-1:0]              in_inst,
  input  logic [cpu_pkg::REG_ADDR_W-1:0] in_rd,
  input  logic                           in_map_en,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [INST_W-1:0]              out_inst,
  output logic [cpu_pkg::REG_ADDR_W-1:0] out_rd,
  output logic                           out_map_en,
  output logic [PTR_W:0]                 count
);

  import cpu_pkg::*;

  typedef struct packed {
    logic [INST_W-1:0]     inst;
    logic [REG_ADDR_W-1:0] rd;
    logic                  map_en;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  logic             empty;
  logic             push;
  logic             bypass;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

`ifdef DISPATCH_BYPASS_EN
  assign bypass = empty && in_valid && out_ready && !flush;
`else
  assign bypass = 1'b0;
`endif

  dispatch_queue_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .bypass    (bypass),
    .in_ready  (in_ready),
    .empty     (empty),
    .push      (push),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{inst: in_inst, rd: in_rd, map_en: in_map_en};
    end
  end

  assign head = mem[rd_ptr];

  // Outputs are forced to zero when empty so stale storage never leaks out.
  always_comb begin
    out_valid  = !empty;
    out_inst   = '0;
    out_rd     = '0;
    out_map_en = 1'b0;
    if (bypass) begin
      out_valid  = 1'b1;
      out_inst   = in_inst;
      out_rd     = in_rd;
      out_map_en = in_map_en;
    end else if (!empty) begin
      out_inst   = head.inst;
      out_rd     = head.rd;
      out_map_en = head.map_en;
    end
  end

endmodule
